inst_prefetch_queue: RTL and testbench

- Parametrised instruction-fetch front end that replaces the single-entry fetch stage.
- Issues sequential fetch requests to instruction memory, which may have variable latency, and buffers up to DEPTH returned instructions with their PCs.
- Presents them to decode under a hold/ready handshake.
- A jump redirect flushes the queue and discards stale in-flight responses. Sits between instruction memory and the instruction decoder, driven by the control block's jmp_vld/jmp_addr/hold.

---
 rtl/inst_prefetch_queue_pkg.sv | 19 +
 rtl/inst_prefetch_queue_if.sv | 32 +++
 rtl/inst_prefetch_queue_pfq_fifo.sv | 63 ++++++
 rtl/inst_prefetch_queue.sv | 124 ++++++++++++
 tb/tb_inst_prefetch_queue.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   PC_INC        : byte step between sequential fetches
//   PC_ALIGN_LSB  : value forced into the two low PC bits (word alignment)
//   XLEN_DEF      : default PC / instruction width
//   RESET_PC_DEF  : default first fetch address after reset
//   pfq_entry_t   : {pc, inst} queue entry at the default width
package inst_prefetch_queue_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          PC_INC       = 4;
  localparam logic [1:0]  PC_ALIGN_LSB = 2'b00;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
  } pfq_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, instruction memory, control and decode.
//   control : jmp_vld, jmp_addr, hold
//   memory  : mem_req_vld/rdy/addr (request), mem_rsp_vld/data (in-order response)
//   decode  : IF_vld, IF_pc, IF_inst (head entry), q_count (occupancy)
// master = the prefetch queue, slave = its environment (memory, control, decode).
interface inst_prefetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                         jmp_vld;
  logic [XLEN-1:0]              jmp_addr;
  logic                         hold;
  logic                         mem_req_vld;
  logic                         mem_req_rdy;
  logic [XLEN-1:0]              mem_req_addr;
  logic                         mem_rsp_vld;
  logic [XLEN-1:0]              mem_rsp_data;
  logic                         IF_vld;
  logic [XLEN-1:0]              IF_pc;
  logic [XLEN-1:0]              IF_inst;
  logic [$clog2(DEPTH+1)-1:0]   q_count;

  modport master (
    input  jmp_vld, jmp_addr, hold, mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    output mem_req_vld, mem_req_addr, IF_vld, IF_pc, IF_inst, q_count
  );

  modport slave (
    output jmp_vld, jmp_addr, hold, mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    input  mem_req_vld, mem_req_addr, IF_vld, IF_pc, IF_inst, q_count
  );
endinterface

// File: rtl/inst_prefetch_queue_pfq_fifo.sv
// pfq_fifo: DEPTH-entry synchronous FIFO with combinational head read.
//   clk, rst  : rising-edge clock, asynchronous active-low reset
//   push_i    : write din_i at tail (caller guarantees not full)
//   pop_i     : drop head entry (caller guarantees not empty)
//   clr_i     : empty the FIFO; wins over push/pop
//   head_o    : current head entry (stale data when empty; caller masks)
//   count_o   : occupied entries
module pfq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  input  logic                       clr_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= din_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction prefetcher with a DEPTH-entry
// {pc, inst} queue toward decode.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : inst_prefetch_queue_if.master (control, memory request/response,
//          decode head entry and occupancy)
// Requests are credit limited: queued + outstanding + to-be-dropped never
// exceeds DEPTH, so every response has a guaranteed slot. A redirect empties
// the queue and turns all outstanding requests into responses to discard.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = CW + 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   q_count;
  logic [CW-1:0]   pending;
  logic [SW-1:0]   credit_used;
  logic [XLEN-1:0] jmp_tgt;
  logic [2*XLEN-1:0] head_raw;
  entry_t          head, push_ent;
  logic            req_vld, req_fire, rsp_drop, rsp_take, pop, if_vld;
  logic            unused_jmp_lsb;

  assign unused_jmp_lsb = ^bus.jmp_addr[1:0];
  assign jmp_tgt        = {bus.jmp_addr[XLEN-1:2], PC_ALIGN_LSB};

  // Everything that may still occupy a queue slot.
  assign credit_used = SW'(q_count) + SW'(outst_q) + SW'(drop_q);
  assign pending     = drop_q + outst_q;

  // Gated by rst so no request is advertised while held in reset.
  assign req_vld  = rst && !bus.jmp_vld && (credit_used < SW'(DEPTH));
  assign req_fire = req_vld && bus.mem_req_rdy;

  // Stale responses are consumed first; a response with nothing pending is ignored.
  assign rsp_drop = bus.mem_rsp_vld && (drop_q != '0);
  assign rsp_take = bus.mem_rsp_vld && (drop_q == '0) && (outst_q != '0) && !bus.jmp_vld;

  assign if_vld = (q_count != '0);
  assign pop    = if_vld && !bus.hold && !bus.jmp_vld;

  assign push_ent = '{pc: rsp_pc_q, inst: bus.mem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (bus.jmp_vld) begin
      fetch_pc_d = jmp_tgt;
      rsp_pc_d   = jmp_tgt;
      outst_d    = '0;
      // A response in the redirect cycle retires one pending request either way.
      drop_d     = (bus.mem_rsp_vld && pending != '0) ? pending - CW'(1) : pending;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
      if (rsp_take) rsp_pc_d   = rsp_pc_q + XLEN'(PC_INC);
      if (rsp_drop) drop_d     = drop_q - CW'(1);
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_take);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  pfq_fifo #(
    .DEPTH (DEPTH),
    .W     (2*XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_take),
    .din_i   (push_ent),
    .pop_i   (pop),
    .clr_i   (bus.jmp_vld),
    .head_o  (head_raw),
    .count_o (q_count)
  );

  assign head = entry_t'(head_raw);

  assign bus.mem_req_vld  = req_vld;
  assign bus.mem_req_addr = fetch_pc_q;
  assign bus.IF_vld       = if_vld;
  assign bus.IF_pc        = if_vld ? head.pc   : '0;
  assign bus.IF_inst      = if_vld ? head.inst : '0;
  assign bus.q_count      = q_count;

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    bus.mem_rsp_vld |-> (outst_q != '0 || drop_q != '0));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
    credit_used <= SW'(DEPTH));
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue. Reference model: a queue of decoded entries,
// a list of issued requests (each flagged stale once a redirect passes it) and
// an in-order memory with per-request latency.
module tb_inst_prefetch_queue;
  import inst_prefetch_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct { int due; logic [31:0] addr; } pend_t;
  typedef struct { logic [31:0] pc; bit stale; } infl_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_prefetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  inst_prefetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0, n_fail = 0;

  // model state
  pfq_entry_t  mq[$];
  infl_t       inflight[$];
  pend_t       pend[$];
  logic [31:0] fetch_pc;
  logic [31:0] popped[$];
  int          cyc = 0, n_acc = 0, first_acc = -1, first_if = -1;
  logic [31:0] s_qc, s_req, s_addr;

  // knobs
  bit k_rst = 0, k_hold = 0, k_rdy = 0, k_jmp = 0;
  logic [31:0] k_jaddr = '0;
  int lat = 1;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] pop_at(int i);
    return (popped.size() > i) ? popped[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic  exp_req, rsp;
    infl_t r;
    @(negedge clk);
    rst              = k_rst;
    bus.hold         = k_hold;
    bus.mem_req_rdy  = k_rdy;
    bus.jmp_vld      = k_jmp;
    bus.jmp_addr     = k_jaddr;
    rsp              = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.mem_rsp_vld  = rsp;
    bus.mem_rsp_data = rsp ? memf(pend[0].addr) : $urandom;
    #1;
    exp_req = k_rst && !k_jmp && (mq.size() + inflight.size() < DEPTH);
    chk("req_vld",  32'(bus.mem_req_vld), 32'(exp_req));
    chk("req_addr", bus.mem_req_addr, fetch_pc);
    chk("if_vld",   32'(bus.IF_vld), 32'(mq.size() != 0));
    chk("if_pc",    bus.IF_pc,   mq.size() ? mq[0].pc   : 32'h0);
    chk("if_inst",  bus.IF_inst, mq.size() ? mq[0].inst : 32'h0);
    chk("q_count",  32'(bus.q_count), 32'(mq.size()));
    s_qc = 32'(bus.q_count); s_req = 32'(bus.mem_req_vld); s_addr = bus.mem_req_addr;
    if (bus.IF_vld && !k_hold && !k_jmp && k_rst) popped.push_back(bus.IF_pc);
    if (bus.IF_vld && first_if < 0) first_if = cyc;
    @(posedge clk);
    if (rsp) void'(pend.pop_front());
    if (k_rst) begin
      if (k_jmp) begin
        mq.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        if (rsp) void'(inflight.pop_front());
        fetch_pc = {k_jaddr[31:2], 2'b00};
      end else begin
        if (mq.size() > 0 && !k_hold) void'(mq.pop_front());
        if (rsp) begin
          r = inflight.pop_front();
          if (!r.stale) mq.push_back('{pc: r.pc, inst: memf(r.pc)});
        end
        if (exp_req && k_rdy) begin
          inflight.push_back('{pc: fetch_pc, stale: 1'b0});
          pend.push_back('{due: cyc + lat, addr: fetch_pc});
          fetch_pc += 4;
          n_acc++;
          if (first_acc < 0) first_acc = cyc;
        end
      end
    end
    cyc++;
  endtask

  // Hold reset for two cycles, abandon memory state, release.
  task automatic do_reset();
    k_rst = 0; k_jmp = 0;
    mq.delete(); inflight.delete(); fetch_pc = 32'h0;
    repeat (2) tick();
    pend.delete(); inflight.delete();
    k_rst = 1;
    popped.delete(); n_acc = 0; first_acc = -1; first_if = -1;
  endtask

  initial begin
    rst = 0; bus.hold = 0; bus.mem_req_rdy = 0; bus.jmp_vld = 0; bus.jmp_addr = '0;
    bus.mem_rsp_vld = 0; bus.mem_rsp_data = '0; fetch_pc = 32'h0;
    #2;
    chk("rst_req_vld", 32'(bus.mem_req_vld), 32'h0);
    chk("rst_if_vld",  32'(bus.IF_vld), 32'h0);
    chk("rst_q_count", 32'(bus.q_count), 32'h0);

    // 1: streaming with 1-cycle memory
    lat = 1; k_rdy = 1; k_hold = 0;
    do_reset();
    repeat (8) tick();
    chk("p1_if_latency", 32'(first_if - first_acc), 32'd2);
    chk("p1_pop0", pop_at(0), 32'h0);
    chk("p1_pop1", pop_at(1), 32'h4);
    chk("p1_pop2", pop_at(2), 32'h8);

    // 2: hold fills the queue, release drains in order
    k_hold = 1;
    do_reset();
    repeat (10) tick();
    chk("p2_qc_full", s_qc, 32'd4);
    chk("p2_req_off", s_req, 32'd0);
    k_hold = 0;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) chk("p2_drain", pop_at(i), 32'(i * 4));

    // 3: toggling ready, 3-cycle latency, contiguous PCs
    lat = 3;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      k_rdy = ($urandom_range(0, 1) == 1);
      tick();
    end
    chk("p3_some_pops", 32'(popped.size() > 8), 32'd1);
    for (int i = 0; i < popped.size(); i++) chk("p3_contig", popped[i], 32'(i * 4));

    // 4: redirect with 2 queued and 2 outstanding
    lat = 1; k_rdy = 1; k_hold = 1;
    do_reset();
    for (int i = 0; i < 10 && n_acc < 2; i++) tick();
    k_rdy = 0;
    for (int i = 0; i < 10 && inflight.size() != 0; i++) tick();
    lat = 4; k_rdy = 1;
    for (int i = 0; i < 10 && n_acc < 4; i++) tick();
    chk("p4_accepts", 32'(n_acc), 32'd4);
    k_rdy = 0; k_jmp = 1; k_jaddr = 32'h100;
    tick();
    chk("p4_qc_at_jmp", s_qc, 32'd2);
    k_jmp = 0; k_hold = 0; k_rdy = 1; lat = 1;
    popped.delete();
    repeat (14) tick();
    chk("p4_pop0", pop_at(0), 32'h100);
    chk("p4_pop1", pop_at(1), 32'h104);

    // 5: redirect on a response+pop cycle, then a misaligned re-target
    lat = 1; k_rdy = 1; k_hold = 0;
    do_reset();
    repeat (6) tick();
    popped.delete();
    k_jmp = 1; k_jaddr = 32'h300; tick();
    k_jaddr = 32'h203; tick();
    k_jmp = 0;
    repeat (8) tick();
    chk("p5_pop0", pop_at(0), 32'h200);
    chk("p5_pop1", pop_at(1), 32'h204);

    // 6: asynchronous reset with 3 outstanding
    lat = 4; k_rdy = 1; k_hold = 1;
    do_reset();
    for (int i = 0; i < 10 && inflight.size() < 3; i++) tick();
    @(negedge clk); #2;
    rst = 0; k_rst = 0;
    mq.delete(); inflight.delete(); fetch_pc = 32'h0;
    #1;
    chk("p6_req_vld", 32'(bus.mem_req_vld), 32'h0);
    chk("p6_if_vld",  32'(bus.IF_vld), 32'h0);
    chk("p6_if_pc",   bus.IF_pc, 32'h0);
    chk("p6_if_inst", bus.IF_inst, 32'h0);
    chk("p6_q_count", 32'(bus.q_count), 32'h0);
    repeat (4) tick();
    pend.delete(); inflight.delete();
    k_rst = 1; k_hold = 0; lat = 1; popped.delete();
    tick();
    chk("p6_first_req", s_req, 32'd1);
    chk("p6_first_addr", s_addr, 32'h0);
    repeat (8) tick();
    chk("p6_pop0", pop_at(0), 32'h0);

    // 7: random mix of stalls, ready, latency and redirects
    do_reset();
    for (int i = 0; i < 250; i++) begin
      k_hold  = ($urandom_range(0, 9) < 3);
      k_rdy   = ($urandom_range(0, 9) < 7);
      k_jmp   = ($urandom_range(0, 19) == 0);
      k_jaddr = $urandom;
      lat     = $urandom_range(1, 3);
      tick();
    end
    k_jmp = 0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before end of stimulus");
    $fatal(1, "timeout");
  end
endmodule
